// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall replay and redirect squash in front of a registered instruction memory.
// Optional FETCH_MISALIGN_EN halts on misaligned redirect targets; by default targets are word-aligned silently.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] mem_pc_q;
    logic        mem_valid_q;
    logic [31:0] redirect_target;
    logic        redirect_bad;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    assign redirect_bad   = |redirect_pc[1:0];
    assign fetch_misalign = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state_q != HALT && redirect && redirect_bad) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign redirect_bad   = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // While stalled, re-present the address of the word already on inst so memory keeps returning it.
    assign inst_addr = (stall && !redirect && state_q != HALT) ? mem_pc_q : pc_q;
    assign id_pc4    = id_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            mem_pc_q    <= RESET_PC;
            mem_valid_q <= 1'b0;
            id_inst     <= 32'h0;
            id_pc       <= 32'h0;
            id_valid    <= 1'b0;
        end else begin
            case (state_q)
                HALT: ;
                default: begin
                    if (redirect) begin
                        id_valid    <= 1'b0;
                        mem_valid_q <= 1'b0;
                        if (redirect_bad) begin
                            state_q <= HALT;
                        end else begin
                            pc_q <= redirect_target;
                        end
                    end else if (!stall) begin
                        id_inst     <= inst;
                        id_pc       <= mem_pc_q;
                        id_valid    <= mem_valid_q;
                        mem_pc_q    <= pc_q;
                        mem_valid_q <= 1'b1;
                        pc_q        <= pc_q + 32'd4;
                        state_q     <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a stream-level model predicts which addresses reach decode and when.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
`ifdef FETCH_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        fetch_misalign;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_addr(inst_addr), .inst(inst),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
        .id_valid(id_valid), .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory: every address holds a distinct word derived from the address itself.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    logic [31:0] mem_addr_q = 32'h0;
    always @(posedge clk) mem_addr_q <= inst_addr;
    assign inst = mem_word(mem_addr_q);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] next_pc;
    int          fill;
    bit          halted;
    bit          exp_valid;
    bit          exp_misalign;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Model of the delivered instruction stream: one pipeline-fill bubble after reset or redirect, then sequential.
    task automatic modelReset();
        next_pc      = RESET_PC;
        fill         = 1;
        halted       = 1'b0;
        exp_valid    = 1'b0;
        exp_misalign = 1'b0;
        sb.delete();
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, advance to the next falling edge.
    task automatic applyStimulus(input bit s, input bit r, input logic [31:0] tgt);
        stall       = s;
        redirect    = r;
        redirect_pc = tgt;
        if (!halted) begin
            if (r) begin
                exp_valid = 1'b0;
                if (MISALIGN_EN && tgt % 4 != 0) begin
                    halted       = 1'b1;
                    exp_misalign = 1'b1;
                end else begin
                    next_pc = tgt - (tgt % 4);
                    fill    = 1;
                end
            end else if (!s) begin
                if (fill > 0) begin
                    fill--;
                    exp_valid = 1'b0;
                end else begin
                    sb.push_back('{pc: next_pc, word: mem_word(next_pc)});
                    next_pc   = next_pc + 4;
                    exp_valid = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, whatever stall/redirect currently are, and releases it at a falling edge.
    task automatic doReset();
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_id_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("rst_inst_addr", inst_addr, RESET_PC);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_inst", id_inst, 32'h0);
        checkOutput("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
        repeat (2) @(negedge clk);
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rst         = 1'b0;
    endtask

    // Monitor: after every rising edge that advanced the pipe, a valid id_* is a new instruction to retire.
    always @(posedge clk) begin
        bit adv;
        exp_t e;
        adv = !stall && !redirect;
        #1;
        if (!rst) begin
            checkOutput("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
            checkOutput("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, exp_misalign});
            if (adv && id_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got id_pc %h expected no instruction", id_pc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("id_pc", id_pc, e.pc);
                    checkOutput("id_inst", id_inst, e.word);
                    checkOutput("id_pc4", id_pc4, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        modelReset();
        @(negedge clk);
        doReset();

        // Sequential run across the 32-bit wrap, then a 3-cycle stall while id_pc=4.
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("pre_stall_pc", id_pc, 32'h4);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_hold_pc", id_pc, 32'h4);
        checkOutput("stall_hold_inst", id_inst, mem_word(32'h4));
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Plain redirect, then redirect colliding with stall.
        applyStimulus(1'b0, 1'b1, 32'h40);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h20);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_stall_pc", id_pc, 32'h20);

        // Misaligned target: halts with the feature, otherwise fetches the aligned word.
        applyStimulus(1'b0, 1'b1, 32'h42);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        if (!MISALIGN_EN) checkOutput("misalign_masked_pc", id_pc, 32'h40);
        applyStimulus(1'b1, 1'b1, 32'h80);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset during a stall and during a redirect.
        applyStimulus(1'b1, 1'b0, 32'h0);
        doReset();
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        doReset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit          s;
            bit          r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 11) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) t[31:8] = 24'hFFFFFF;
            if (i % 97 == 96) doReset();
            else applyStimulus(s, r, t);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  downstream cannot accept; hold all fetch state and outputs.
REQ-005 redirect  input  1  taken branch/jump; squash in-flight fetches.
REQ-006 redirect_pc  input  32  byte target address, sampled when redirect=1.
REQ-007 inst_addr  output  32  byte address to instruction memory; memory registers it on the edge and returns the word on inst one cycle later.
REQ-008 inst  input  32  big-endian word from instruction memory.
REQ-009 id_inst  output  32  registered instruction to decode.
REQ-010 id_pc  output  32  byte address of id_inst.
REQ-011 id_pc4  output  32  id_pc + 4, modulo 2^32.
REQ-012 id_valid  output  1  id_inst/id_pc hold a real instruction.
REQ-013 fetch_misalign  output  1  sticky misaligned-target flag.

Function
REQ-014 Internal state: pc_q (next fetch address), mem_pc_q/mem_valid_q (address and validity of the word currently on inst), FSM {BOOT, RUN, HALT}.
REQ-015 inst_addr = mem_pc_q when stall=1 and redirect=0, else pc_q; the stall replay keeps inst equal to mem[mem_pc_q].
REQ-016 Normal edge (redirect=0, stall=0, RUN/BOOT): id_inst<=inst, id_pc<=mem_pc_q, id_valid<=mem_valid_q, mem_pc_q<=pc_q, mem_valid_q<=1, pc_q<=pc_q+4, BOOT->RUN.
REQ-017 Stall edge (redirect=0, stall=1): pc_q, mem_pc_q, mem_valid_q, id_* all unchanged.
REQ-018 Redirect edge (redirect=1, any stall): id_valid<=0, mem_valid_q<=0, pc_q<=redirect_pc; redirect has priority over stall.
REQ-019 Latency: first id_valid=1 at the 2nd rising edge after rst deasserts, carrying mem[RESET_PC]; after a redirect at edge N, id_valid=0 following edges N and N+1, target instruction valid after N+2.
REQ-020 pc_q increments wrap 32'hFFFF_FFFC -> 32'h0000_0000; no range check against memory depth.
REQ-021 id_pc4 is combinational from id_pc.
REQ-022 HALT: pc_q, mem_pc_q, inst_addr frozen, id_valid=0, stall/redirect ignored; exit only by rst.

Reset
REQ-023 rst=1 asynchronously forces: pc_q=RESET_PC, mem_pc_q=RESET_PC, mem_valid_q=0, id_inst=0, id_pc=0, id_valid=0, fetch_misalign=0, FSM=BOOT.
REQ-024 rst asserted mid-stall or mid-redirect discards all in-flight fetches; no partial state survives.
REQ-025 During rst, inst_addr=RESET_PC.

Configuration
REQ-026 Macro FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 and FSM=HALT at that edge; id_valid<=0; pc_q unchanged.
REQ-027 FETCH_MISALIGN_EN undefined: redirect_pc[1:0] forced to 2'b00 before loading pc_q; HALT unreachable; fetch_misalign tied 0.

Verification
REQ-028 Reset release, mem[0..11]=A,B,C, no stall -> id_valid at edge 2; id_inst A,B,C on consecutive edges; id_pc 0,4,8; id_pc4 4,8,12.
REQ-029 stall=1 for 3 cycles while id_inst=B (id_pc=4) -> id_inst/id_pc hold B/4; release -> C/8 next edge, no instruction skipped or duplicated.
REQ-030 redirect=1, redirect_pc=0x40 while id_pc=8 -> id_valid=0 for 2 edges, then id_inst=mem[0x40], id_pc=0x40.
REQ-031 redirect=1 and stall=1 same cycle, target 0x20 -> redirect wins; id_pc=0x20 two edges later.
REQ-032 RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 Target 0x42: with FETCH_MISALIGN_EN -> fetch_misalign=1 sticky, id_valid=0 until rst; without -> fetch from 0x40, fetch_misalign=0.
